// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier with a start/busy/done handshake.
// Handles signed or unsigned operands and performs one Booth step per clock.
module booth_mult_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 op_signed,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int E  = WIDTH + 1;
    localparam int CW = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] ITER = CW'(WIDTH + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t               state_q;
    logic [E:0]           a_q;
    logic [E-1:0]         q_q;
    logic [E-1:0]         m_q;
    logic                 qm1_q;
    logic [CW-1:0]        cnt_q;
    logic                 busy_q;
    logic                 done_q;
    logic [2*WIDTH-1:0]   product_q;

    logic [E-1:0]         mc_ext_d;
    logic [E-1:0]         mp_ext_d;
    logic [E:0]           m_wide_d;
    logic [E:0]           sum_d;
    logic [E:0]           a_d;
    logic [E-1:0]         q_d;
    logic                 qm1_d;
    logic [2*WIDTH-1:0]   result_d;

    // One extra operand bit lets unsigned values ride through the signed Booth datapath.
    always_comb begin
        mc_ext_d = {op_signed & multiplicand[WIDTH-1], multiplicand};
        mp_ext_d = {op_signed & multiplier[WIDTH-1], multiplier};
    end

    // Single Booth step: conditional add/subtract, then arithmetic shift of {A,Q,Q_-1}.
    always_comb begin
        m_wide_d = {m_q[E-1], m_q};
        case ({q_q[0], qm1_q})
            2'b01:   sum_d = a_q + m_wide_d;
            2'b10:   sum_d = a_q - m_wide_d;
            default: sum_d = a_q;
        endcase
        a_d      = {sum_d[E], sum_d[E:1]};
        q_d      = {sum_d[0], q_q[E-1:1]};
        qm1_d    = q_q[0];
        result_d = {a_d[WIDTH-2:0], q_d};
    end

    // Control FSM and datapath registers; outputs are registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            a_q       <= '0;
            q_q       <= '0;
            m_q       <= '0;
            qm1_q     <= 1'b0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        m_q     <= mc_ext_d;
                        q_q     <= mp_ext_d;
                        a_q     <= '0;
                        qm1_q   <= 1'b0;
                        cnt_q   <= ITER;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    a_q   <= a_d;
                    q_q   <= q_d;
                    qm1_q <= qm1_d;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        product_q <= result_d;
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= IDLE;
                    end else begin
                        done_q    <= 1'b0;
                        state_q   <= RUN;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Scoreboard bench for booth_mult_seq at WIDTH 8 (directed), 4 (exhaustive) and 16 (random).
module tb_booth_mult_seq;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        st8, sg8, busy8, done8;
    logic [7:0]  mc8, mp8;
    logic [15:0] product8;
    logic        st4, sg4, busy4, done4;
    logic [3:0]  mc4, mp4;
    logic [7:0]  product4;
    logic        st16, sg16, busy16, done16;
    logic [15:0] mc16, mp16;
    logic [31:0] product16;

    booth_mult_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(st8), .op_signed(sg8),
        .multiplicand(mc8), .multiplier(mp8),
        .busy(busy8), .done(done8), .product(product8));
    booth_mult_seq #(.WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .start(st4), .op_signed(sg4),
        .multiplicand(mc4), .multiplier(mp4),
        .busy(busy4), .done(done4), .product(product4));
    booth_mult_seq #(.WIDTH(16)) dut16 (
        .clk(clk), .reset(reset), .start(st16), .op_signed(sg16),
        .multiplicand(mc16), .multiplier(mp16),
        .busy(busy16), .done(done16), .product(product16));

    logic [63:0] q8[$];
    logic [63:0] q4[$];
    logic [63:0] q16[$];

    int chk_d = 0, err_d = 0;
    int chk_m8 = 0, err_m8 = 0;
    int chk_m4 = 0, err_m4 = 0;
    int chk_m16 = 0, err_m16 = 0;

    // Plain-arithmetic reference: interpret operands per mode, multiply, keep 2*w bits.
    function automatic logic [63:0] ref_mul(input int w, input logic sg,
                                            input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, p;
        sa = longint'(a);
        sb = longint'(b);
        if (sg && a[w-1]) sa = sa - (longint'(1) << w);
        if (sg && b[w-1]) sb = sb - (longint'(1) << w);
        p = sa * sb;
        return 64'(p) & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_d++;
        if (!ok) begin
            err_d++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic go8(input logic sg, input logic [7:0] a, input logic [7:0] b, input bit push);
        int n = 0;
        while (busy8 && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) chk(1'b0, "go8_timeout", 64'(busy8), 64'd0);
        sg8 = sg; mc8 = a; mp8 = b; st8 = 1'b1;
        if (push) q8.push_back(ref_mul(8, sg, 32'(a), 32'(b)));
        @(posedge clk); #1;
        st8 = 1'b0;
        mc8 = 8'($urandom); mp8 = 8'($urandom); sg8 = ~sg;
    endtask

    task automatic go4(input logic sg, input logic [3:0] a, input logic [3:0] b);
        int n = 0;
        while (busy4 && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) chk(1'b0, "go4_timeout", 64'(busy4), 64'd0);
        sg4 = sg; mc4 = a; mp4 = b; st4 = 1'b1;
        q4.push_back(ref_mul(4, sg, 32'(a), 32'(b)));
        @(posedge clk); #1;
        st4 = 1'b0;
    endtask

    task automatic go16(input logic sg, input logic [15:0] a, input logic [15:0] b);
        int n = 0;
        while (busy16 && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) chk(1'b0, "go16_timeout", 64'(busy16), 64'd0);
        sg16 = sg; mc16 = a; mp16 = b; st16 = 1'b1;
        q16.push_back(ref_mul(16, sg, 32'(a), 32'(b)));
        @(posedge clk); #1;
        st16 = 1'b0;
    endtask

    // Called just after the accepting edge: busy for 9 cycles, then a clean 1-cycle done.
    task automatic lat8(input logic [15:0] exp, input string name);
        for (int i = 0; i < 9; i++) begin
            chk(busy8 === 1'b1 && done8 === 1'b0, {name, "_busy"}, {62'd0, busy8, done8}, 64'd2);
            @(posedge clk); #1;
        end
        chk(done8 === 1'b1 && busy8 === 1'b0, {name, "_done"}, {62'd0, busy8, done8}, 64'd1);
        chk(product8 === exp, {name, "_prod"}, 64'(product8), 64'(exp));
    endtask

    task automatic idle_all();
        int n = 0;
        while ((busy8 || done8 || busy4 || done4 || busy16 || done16) && n < 500) begin
            @(negedge clk); n++;
        end
        if (n >= 500) chk(1'b0, "idle_timeout", 64'(n), 64'd0);
        @(negedge clk);
    endtask

    logic [15:0] last8 = 16'd0;

    // W=8 monitor: compare on done, and the product must hold between completions.
    always @(negedge clk) begin
        if (reset) begin
            last8 = 16'd0;
        end else if (done8) begin
            chk_m8++;
            if (q8.size() == 0) begin
                err_m8++;
                $display("FAIL mon8_unexpected_done: got %0h expected no done at %0t", product8, $time);
            end else begin
                logic [63:0] e;
                e = q8.pop_front();
                if (product8 !== e[15:0]) begin
                    err_m8++;
                    $display("FAIL mon8_product: got %0h expected %0h at %0t", product8, e[15:0], $time);
                end
            end
            last8 = product8;
        end else begin
            chk_m8++;
            if (product8 !== last8) begin
                err_m8++;
                $display("FAIL mon8_hold: got %0h expected %0h at %0t", product8, last8, $time);
            end
        end
    end

    // W=4 monitor.
    always @(negedge clk) begin
        if (!reset && done4) begin
            chk_m4++;
            if (q4.size() == 0) begin
                err_m4++;
                $display("FAIL mon4_unexpected_done: got %0h at %0t", product4, $time);
            end else begin
                logic [63:0] e;
                e = q4.pop_front();
                if (product4 !== e[7:0]) begin
                    err_m4++;
                    $display("FAIL mon4_product: got %0h expected %0h at %0t", product4, e[7:0], $time);
                end
            end
        end
    end

    // W=16 monitor.
    always @(negedge clk) begin
        if (!reset && done16) begin
            chk_m16++;
            if (q16.size() == 0) begin
                err_m16++;
                $display("FAIL mon16_unexpected_done: got %0h at %0t", product16, $time);
            end else begin
                logic [63:0] e;
                e = q16.pop_front();
                if (product16 !== e[31:0]) begin
                    err_m16++;
                    $display("FAIL mon16_product: got %0h expected %0h at %0t", product16, e[31:0], $time);
                end
            end
        end
    end

    logic [15:0] corners [5];

    initial begin
        reset = 1'b1;
        st8 = 1'b0; sg8 = 1'b0; mc8 = 8'd0; mp8 = 8'd0;
        st4 = 1'b0; sg4 = 1'b0; mc4 = 4'd0; mp4 = 4'd0;
        st16 = 1'b0; sg16 = 1'b0; mc16 = 16'd0; mp16 = 16'd0;
        corners[0] = 16'h0000; corners[1] = 16'h0001; corners[2] = 16'h7FFF;
        corners[3] = 16'h8000; corners[4] = 16'hFFFF;
        #2;
        chk(busy8 === 1'b0 && done8 === 1'b0 && product8 === 16'd0, "reset_state",
            {46'd0, busy8, done8, product8}, 64'd0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        go8(1'b0, 8'd255, 8'd255, 1'b1);
        lat8(16'hFE01, "t2_255x255");
        @(posedge clk); #1;
        chk(done8 === 1'b0, "t2_done_clears", 64'(done8), 64'd0);

        go8(1'b1, 8'h80, 8'h80, 1'b1);
        lat8(16'h4000, "t3_m128xm128");
        go8(1'b1, 8'hFF, 8'h7F, 1'b1);
        lat8(16'hFF81, "t3_m1x127");
        go8(1'b1, 8'h80, 8'h7F, 1'b1);
        lat8(16'hC080, "t3_m128x127");

        go8(1'b1, 8'd100, 8'hFD, 1'b1);
        @(posedge clk); @(posedge clk); #1;
        sg8 = 1'b0; mc8 = 8'h11; mp8 = 8'h22; st8 = 1'b1;
        @(posedge clk); #1;
        st8 = 1'b0;
        begin
            int n = 0;
            @(negedge clk);
            while (!done8 && n < 50) begin @(negedge clk); n++; end
            chk(done8 === 1'b1 && busy8 === 1'b0, "t4_done_cycle_idle", {62'd0, busy8, done8}, 64'd1);
        end
        go8(1'b0, 8'd200, 8'd50, 1'b1);
        lat8(16'd10000, "t4_back_to_back");

        idle_all();
        go8(1'b0, 8'd100, 8'd3, 1'b0);
        @(posedge clk); @(posedge clk); @(posedge clk); #2;
        reset = 1'b1;
        #1;
        chk(busy8 === 1'b0 && done8 === 1'b0 && product8 === 16'd0, "t5_async_reset",
            {46'd0, busy8, done8, product8}, 64'd0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        repeat (15) @(negedge clk);
        chk(product8 === 16'd0 && busy8 === 1'b0, "t5_no_done_after", {47'd0, busy8, product8}, 64'd0);
        go8(1'b0, 8'd7, 8'd6, 1'b1);
        lat8(16'h002A, "t5_7x6");

        for (int i = 0; i < 40; i++)
            go8(1'($urandom), 8'($urandom), 8'($urandom), 1'b1);
        idle_all();

        for (int s = 0; s < 2; s++)
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++)
                    go4(1'(s), 4'(a), 4'(b));
        idle_all();

        for (int s = 0; s < 2; s++)
            for (int a = 0; a < 5; a++)
                for (int b = 0; b < 5; b++)
                    go16(1'(s), corners[a], corners[b]);
        for (int i = 0; i < 1500; i++) begin
            logic [15:0] ra, rb;
            ra = ($urandom_range(0, 7) == 0) ? corners[$urandom_range(0, 4)] : 16'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? corners[$urandom_range(0, 4)] : 16'($urandom);
            go16(1'($urandom), ra, rb);
        end
        idle_all();

        chk(q8.size() == 0, "q8_drained", 64'(q8.size()), 64'd0);
        chk(q4.size() == 0, "q4_drained", 64'(q4.size()), 64'd0);
        chk(q16.size() == 0, "q16_drained", 64'(q16.size()), 64'd0);
        chk(chk_m4 == 512, "w4_op_count", 64'(chk_m4), 64'd512);

        $display("Result: errors=%0d of %0d checks",
                 err_d + err_m8 + err_m4 + err_m16, chk_d + chk_m8 + chk_m4 + chk_m16);
        $finish;
    end

endmodule
